// File: rtl/prog_loader.sv
// Boot-time program loader: takes a little-endian byte stream (count, words, checksum), writes
// each word through a shared memory write port and holds the core in reset until verified.
module prog_loader #(
  parameter int unsigned NUM_MEM_WORDS  = 65536,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned BOOT_WORD_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              prog_wr_en,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wr_data,
  input  logic              prog_wr_ready,
  output logic              programming_done,
  output logic              load_error,
  output logic              core_rst,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {StHdr, StData, StWrite, StCsum, StDone, StErr} state_e;

  state_e      state;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic [31:0] word_cnt;
  logic [31:0] csum;

  logic          rx_fire;
  logic          last_byte;
  logic [31:0]   field;
  logic [ADDR_W:0] words_next;

  // Bytes shift in from the top so the first byte of a field lands in bits [7:0].
  assign field      = {rx_data, shreg[31:8]};
  assign rx_fire    = rx_valid & rx_ready;
  assign last_byte  = rx_fire & (byte_idx == 2'd3);
  assign words_next = words_loaded + (ADDR_W + 1)'(1);
  assign core_rst   = rst | ~programming_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StHdr;
      byte_idx         <= 2'd0;
      shreg            <= 32'd0;
      word_cnt         <= 32'd0;
      csum             <= 32'd0;
      rx_ready         <= 1'b0;
      prog_wr_en       <= 1'b0;
      prog_addr        <= ADDR_W'(BOOT_WORD_ADDR);
      prog_wr_data     <= 32'd0;
      programming_done <= 1'b0;
      load_error       <= 1'b0;
      words_loaded     <= '0;
    end else begin
      if (rx_fire) begin
        shreg    <= field;
        byte_idx <= byte_idx + 2'd1;
      end

      case (state)
        StHdr: begin
          rx_ready <= 1'b1;
          if (last_byte) begin
            word_cnt <= field;
            if (field > NUM_MEM_WORDS) begin
              state      <= StErr;
              load_error <= 1'b1;
            end else if (field == 32'd0) begin
              state <= StCsum;
            end else begin
              state <= StData;
            end
          end
        end

        StData: begin
          if (last_byte) begin
            prog_wr_en   <= 1'b1;
            prog_wr_data <= field;
            csum         <= csum + field;
            rx_ready     <= 1'b0;
            state        <= StWrite;
          end
        end

        StWrite: begin
          if (prog_wr_ready) begin
            prog_wr_en   <= 1'b0;
            prog_addr    <= prog_addr + ADDR_W'(1);
            words_loaded <= words_next;
            rx_ready     <= 1'b1;
            state        <= (32'(words_next) == word_cnt) ? StCsum : StData;
          end
        end

        StCsum: begin
          if (last_byte) begin
            if (field == csum) begin
              programming_done <= 1'b1;
              rx_ready         <= 1'b0;
              state            <= StDone;
            end else begin
              load_error <= 1'b1;
              state      <= StErr;
            end
          end
        end

        StDone: rx_ready <= 1'b0;

        // Keep draining so an upstream UART never backs up after a bad image.
        StErr: rx_ready <= 1'b1;

        default: begin
          state      <= StErr;
          load_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed images from the test plan plus randomized images
// scored against a count/sum model of the image format.
module tb_prog_loader;

  localparam int unsigned NW   = 65536;
  localparam int unsigned AW   = 16;
  localparam int unsigned BOOT = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          prog_wr_en;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_wr_data;
  logic          prog_wr_ready = 1'b0;
  logic          programming_done;
  logic          load_error;
  logic          core_rst;
  logic [AW:0]   words_loaded;

  prog_loader #(
    .NUM_MEM_WORDS (NW),
    .ADDR_W        (AW),
    .BOOT_WORD_ADDR(BOOT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .prog_wr_en      (prog_wr_en),
    .prog_addr       (prog_addr),
    .prog_wr_data    (prog_wr_data),
    .prog_wr_ready   (prog_wr_ready),
    .programming_done(programming_done),
    .load_error      (load_error),
    .core_rst        (core_rst),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;

  logic [31:0]   img_n;
  logic [31:0]   img_csum;
  logic [31:0]   img_words[$];
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  always @(negedge clk) prog_wr_ready = ($urandom_range(0, 99) < ready_pct);

  always @(posedge clk) begin
    if (!rst && prog_wr_en && prog_wr_ready) begin
      log_addr.push_back(prog_addr);
      log_data.push_back(prog_wr_data);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int budget;
    bit sent;
    while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
    sent = 1'b0;
    budget = 0;
    while (!sent && budget < 500) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      if (rx_ready) begin
        @(posedge clk);
        sent = 1'b1;
      end
      budget++;
    end
    #1 rx_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b, required accept", b,
               rx_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), gap_pct);
  endtask

  // Sends the current image and scores the outcome against the image-format model.
  task automatic test_load(input string name, input int gap_pct);
    logic [31:0] sum;
    bit exp_done;
    bit exp_err;
    int nwr;
    int t;
    send_word(img_n, gap_pct);
    foreach (img_words[i]) send_word(img_words[i], gap_pct);
    checks++;
    if (core_rst !== 1'b1 || programming_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pre_csum: core_rst=%b done=%b, required 1/0", name, core_rst,
               programming_done);
    end
    send_word(img_csum, gap_pct);

    sum = 32'd0;
    foreach (img_words[i]) sum += img_words[i];
    if (img_n > NW) begin
      exp_err = 1'b1; exp_done = 1'b0; nwr = 0;
    end else begin
      exp_done = (sum == img_csum); exp_err = !exp_done; nwr = int'(img_n);
    end

    t = 0;
    while (!(programming_done || load_error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checks++;
    if (programming_done !== exp_done || load_error !== exp_err) begin
      errors++;
      $display("FAIL %s_status: done=%b err=%b, required %b/%b", name, programming_done,
               load_error, exp_done, exp_err);
    end
    checks++;
    if (core_rst !== !exp_done) begin
      errors++;
      $display("FAIL %s_core_rst: got %b, required %b", name, core_rst, !exp_done);
    end
    checks++;
    if (words_loaded !== (AW + 1)'(nwr)) begin
      errors++;
      $display("FAIL %s_words_loaded: got %0d, required %0d", name, words_loaded, nwr);
    end
    checks++;
    if (log_addr.size() != nwr) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, log_addr.size(), nwr);
    end else begin
      for (int i = 0; i < nwr; i++) begin
        checks++;
        if (log_addr[i] !== AW'(BOOT + i) || log_data[i] !== img_words[i]) begin
          errors++;
          $display("FAIL %s_write%0d: got %h@%h, required %h@%h", name, i, log_data[i],
                   log_addr[i], img_words[i], AW'(BOOT + i));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rx_ready !== 1'b0 || prog_wr_en !== 1'b0 || prog_addr !== AW'(BOOT) ||
        prog_wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_port: rdy=%b en=%b addr=%h data=%h, required 0/0/%h/0", rx_ready,
               prog_wr_en, prog_addr, prog_wr_data, AW'(BOOT));
    end
    checks++;
    if (programming_done !== 1'b0 || load_error !== 1'b0 || words_loaded !== '0 ||
        core_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: done=%b err=%b wl=%0d core_rst=%b, required 0/0/0/1",
               programming_done, load_error, words_loaded, core_rst);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hdr_ready: got %b, required 1", rx_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    ready_pct = 100;
    img_n = 32'd2;
    img_words = '{32'h0000_0013, 32'h0010_0093};
    img_csum = 32'h0010_00A6;
    test_load("basic", 0);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_ready: got %b, required 0", rx_ready);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    ready_pct = 100;
    img_n = 32'd2;
    img_words = '{32'h0000_0013, 32'h0010_0093};
    img_csum = 32'h0010_00A7;
    test_load("bad_csum", 0);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_drain_ready: got %b, required 1", rx_ready);
    end
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    checks++;
    if (load_error !== 1'b1 || programming_done !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_sticky: err=%b done=%b core_rst=%b, required 1/0/1", load_error,
               programming_done, core_rst);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    ready_pct = 100;
    img_n = 32'h0001_0001;
    img_words.delete();
    img_csum = 32'hDEAD_BEEF;
    test_load("oversize", 0);
  endtask

  task automatic test_stall();
    logic [31:0] w;
    int t;
    do_reset();
    ready_pct = 0;
    w = $urandom;
    send_word(32'd1, 0);
    send_word(w, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = w[7:0];
      checks++;
      if (prog_wr_en !== 1'b1 || prog_addr !== AW'(BOOT) || prog_wr_data !== w ||
          rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: en=%b addr=%h data=%h rdy=%b, required 1/%h/%h/0", i,
                 prog_wr_en, prog_addr, prog_wr_data, rx_ready, AW'(BOOT), w);
      end
    end
    rx_valid = 1'b0;
    ready_pct = 100;
    send_byte(w[7:0], 0);
    checks++;
    if (log_addr.size() != 1) begin
      errors++;
      $display("FAIL stall_write_before_csum: writes=%0d, required 1", log_addr.size());
    end
    for (int i = 1; i < 4; i++) send_byte(8'(w >> (8 * i)), 0);
    t = 0;
    while (!programming_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (programming_done !== 1'b1 || words_loaded !== (AW + 1)'(1) || log_data.size() != 1 ||
        log_data[0] !== w) begin
      errors++;
      $display("FAIL stall_outcome: done=%b wl=%0d writes=%0d, required 1/1/1 of %h",
               programming_done, words_loaded, log_data.size(), w);
    end
  endtask

  task automatic test_zero();
    do_reset();
    img_n = 32'd0;
    img_words.delete();
    img_csum = 32'd0;
    test_load("zero_ok", 0);
    do_reset();
    img_csum = 32'd1;
    test_load("zero_bad", 0);
  endtask

  task automatic test_reset_midload();
    int t;
    do_reset();
    ready_pct = 70;
    img_n = 32'd8;
    img_words.delete();
    img_csum = 32'd0;
    for (int i = 0; i < 8; i++) begin
      img_words.push_back($urandom);
      img_csum += img_words[i];
    end
    send_word(img_n, 0);
    for (int i = 0; i < 5; i++) send_word(img_words[i], 0);
    t = 0;
    while (words_loaded !== (AW + 1)'(5) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rx_ready !== 1'b0 || prog_wr_en !== 1'b0 || prog_addr !== AW'(BOOT) ||
        prog_wr_data !== 32'd0 || programming_done !== 1'b0 || load_error !== 1'b0 ||
        words_loaded !== '0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL midload_reset: rdy=%b en=%b addr=%h data=%h done=%b err=%b wl=%0d crst=%b",
               rx_ready, prog_wr_en, prog_addr, prog_wr_data, programming_done, load_error,
               words_loaded, core_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    ready_pct = 100;
    test_load("reload", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      do_reset();
      ready_pct = $urandom_range(30, 100);
      img_n = $urandom_range(0, 6);
      img_words.delete();
      img_csum = 32'd0;
      for (int i = 0; i < int'(img_n); i++) begin
        img_words.push_back($urandom);
        img_csum += img_words[i];
      end
      if ($urandom_range(0, 99) < 30) img_csum ^= 32'd1 << $urandom_range(0, 31);
      test_load($sformatf("random%0d", it), $urandom_range(0, 40));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_oversize();
    test_stall();
    test_zero();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
